// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared constants and priority encoder for the key event queue
//
// Contents:
//   MAX_KEYS, KEY_IDX_W  widest supported key set and its index width
//   KEY_CONFIRM..KEY_DOWN  key index assignments of the front panel
//   lowest_set_t / lowest_set  lowest-index-first priority encoder
package key_event_pkg;

    localparam int MAX_KEYS  = 8;
    localparam int KEY_IDX_W = 3;

    localparam logic [KEY_IDX_W-1:0] KEY_CONFIRM = 3'd0;
    localparam logic [KEY_IDX_W-1:0] KEY_BACK    = 3'd1;
    localparam logic [KEY_IDX_W-1:0] KEY_UP      = 3'd2;
    localparam logic [KEY_IDX_W-1:0] KEY_DOWN    = 3'd3;

    typedef struct packed {
        logic                 found;
        logic [KEY_IDX_W-1:0] idx;
    } lowest_set_t;

    // Scan from the top down so the last hit, the lowest set bit, wins.
    function automatic lowest_set_t lowest_set(input logic [MAX_KEYS-1:0] vec);
        lowest_set_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = KEY_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// rtl/key_event_queue_if.sv - key pulse / event stream bundle for key_event_queue
//
// Signals:
//   key_pulse     one-cycle press pulses, one bit per key
//   ev_valid      queue head is valid
//   ev_ready      consumer takes the head this cycle
//   ev_code       key index at the queue head
//   ev_count      queue occupancy
//   overflow      sticky dropped-press flag
//   overflow_clr  clears overflow (only with KEY_EVENT_QUEUE_OVF_CLR_EN)
// Modports: master = debouncers plus consumer side, slave = the queue.
interface key_event_queue_if #(
    parameter int NUM_KEYS = 4,
    parameter int DEPTH    = 4
) ();
    logic [NUM_KEYS-1:0]         key_pulse;
    logic                        ev_valid;
    logic                        ev_ready;
    logic [$clog2(NUM_KEYS)-1:0] ev_code;
    logic [$clog2(DEPTH):0]      ev_count;
    logic                        overflow;
`ifdef KEY_EVENT_QUEUE_OVF_CLR_EN
    logic                        overflow_clr;
`endif

    modport master (
`ifdef KEY_EVENT_QUEUE_OVF_CLR_EN
        output overflow_clr,
`endif
        output key_pulse,
        output ev_ready,
        input  ev_valid,
        input  ev_code,
        input  ev_count,
        input  overflow
    );

    modport slave (
`ifdef KEY_EVENT_QUEUE_OVF_CLR_EN
        input  overflow_clr,
`endif
        input  key_pulse,
        input  ev_ready,
        output ev_valid,
        output ev_code,
        output ev_count,
        output overflow
    );
endinterface

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - small synchronous FIFO with occupancy count
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   push_i       write data_i at the tail (ignored when full without a pop)
//   data_i       entry to write
//   pop_i        advance the head (ignored when empty)
//   head_o       registered entry at the head
//   count_o      occupancy, 0..DEPTH
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - per-key pending latches, lowest-index arbiter and event FIFO
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    key_event_queue_if.slave: key_pulse in, ev_valid/ev_ready/ev_code
//          event stream out, ev_count occupancy, overflow sticky flag
// Optional: KEY_EVENT_QUEUE_OVF_CLR_EN adds overflow_clr to clear overflow.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    key_event_queue_if.slave   bus
);
    localparam int CODE_W = $clog2(NUM_KEYS);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic                overflow_q, overflow_d;
    logic [NUM_KEYS-1:0] pushed_mask;
    logic [NUM_KEYS-1:0] drop_vec;
    lowest_set_t         sel;
    logic                push, pop;
    logic                fifo_full, fifo_empty;
    logic [CODE_W-1:0]   head_code;
    logic [CNT_W-1:0]    fifo_count;

    // Arbitration looks only at registered pending bits; a pulse arriving
    // this cycle becomes pushable on the next one.
    assign sel  = lowest_set(MAX_KEYS'(pending_q));
    assign pop  = !fifo_empty && bus.ev_ready;
    assign push = sel.found && (!fifo_full || pop);

    always_comb begin
        pushed_mask = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            pushed_mask[i] = push && (sel.idx == KEY_IDX_W'(i));
        end
        // A second press on a key that is still waiting has nowhere to go.
        drop_vec  = bus.key_pulse & pending_q & ~pushed_mask;
        pending_d = (pending_q & ~pushed_mask) | bus.key_pulse;
`ifdef KEY_EVENT_QUEUE_OVF_CLR_EN
        overflow_d = (|drop_vec) || (overflow_q && !bus.overflow_clr);
`else
        overflow_d = (|drop_vec) || overflow_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (sel.idx[CODE_W-1:0]),
        .pop_i   (pop),
        .head_o  (head_code),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.ev_valid = !fifo_empty;
    assign bus.ev_code  = head_code;
    assign bus.ev_count = fifo_count;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - directed vector bench for key_event_queue
module tb_key_event_queue;
    import key_event_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    key_event_queue_if #(.NUM_KEYS(4), .DEPTH(4)) bus ();

    key_event_queue #(.NUM_KEYS(4), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] pulse;
        logic       ready;
        logic       valid;
        logic [1:0] code;
        logic [2:0] count;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic [3:0] p, logic r, logic v, logic [1:0] c,
                                logic [2:0] n, logic o);
        vec_t t;
        t.pulse = p; t.ready = r; t.valid = v; t.code = c; t.count = n; t.ovf = o;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] p, input logic r);
        bus.key_pulse = p;
        bus.ev_ready  = r;
    endtask

    task automatic apply(input int idx);
        vec_t t;
        t = tbl[idx];
        drive(t.pulse, t.ready);
        tick();
        chk($sformatf("vec%0d valid", idx), int'(bus.ev_valid), int'(t.valid));
        if (t.valid) chk($sformatf("vec%0d code", idx), int'(bus.ev_code), int'(t.code));
        chk($sformatf("vec%0d count", idx), int'(bus.ev_count), int'(t.count));
        chk($sformatf("vec%0d overflow", idx), int'(bus.overflow), int'(t.ovf));
    endtask

    initial begin
        // Simultaneous press 1011 with backpressure, then drain (0..6)
        tbl.push_back(mk(4'b1011, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 1, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 1, 0, 2, 0));
        tbl.push_back(mk(4'b0000, 0, 1, 0, 3, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 1, 2, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 3, 1, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 0));
        // Fill 3,2,1,0, key 1 waits at full, drain 3,2,1,0,1 (7..18)
        tbl.push_back(mk(4'b1000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 0, 1, 3, 1, 0));
        tbl.push_back(mk(4'b0010, 0, 1, 3, 2, 0));
        tbl.push_back(mk(4'b0001, 0, 1, 3, 3, 0));
        tbl.push_back(mk(4'b0000, 0, 1, 3, 4, 0));
        tbl.push_back(mk(4'b0010, 0, 1, 3, 4, 0));
        tbl.push_back(mk(4'b0000, 0, 1, 3, 4, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 2, 4, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 1, 3, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 0, 2, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 1, 1, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 0));
        // Push and pop at full with key 3 pending (19..28)
        tbl.push_back(mk(4'b0001, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 0, 1, 0, 1, 0));
        tbl.push_back(mk(4'b0100, 0, 1, 0, 2, 0));
        tbl.push_back(mk(4'b0001, 0, 1, 0, 3, 0));
        tbl.push_back(mk(4'b1000, 0, 1, 0, 4, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 1, 4, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 2, 3, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 0, 2, 0));
        tbl.push_back(mk(4'b0000, 1, 1, 3, 1, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 0));
        // Drop: full with key 0 pending, key 0 pulses again (29..40)
        tbl.push_back(mk(4'b1000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 0, 1, 3, 1, 0));
        tbl.push_back(mk(4'b0010, 0, 1, 3, 2, 0));
        tbl.push_back(mk(4'b0001, 0, 1, 3, 3, 0));
        tbl.push_back(mk(4'b0001, 0, 1, 3, 4, 0));
        tbl.push_back(mk(4'b0001, 0, 1, 3, 4, 1));
        tbl.push_back(mk(4'b0000, 0, 1, 3, 4, 1));
        tbl.push_back(mk(4'b0000, 1, 1, 2, 4, 1));
        tbl.push_back(mk(4'b0000, 1, 1, 1, 3, 1));
        tbl.push_back(mk(4'b0000, 1, 1, 0, 2, 1));
        tbl.push_back(mk(4'b0000, 1, 1, 0, 1, 1));
        tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 1));

        drive(4'b0000, 1'b0);
`ifdef KEY_EVENT_QUEUE_OVF_CLR_EN
        bus.overflow_clr = 1'b0;
`endif
        #12 reset = 1'b0;
        #1;
        chk("reset valid", int'(bus.ev_valid), 0);
        chk("reset code", int'(bus.ev_code), 0);
        chk("reset count", int'(bus.ev_count), 0);
        chk("reset overflow", int'(bus.overflow), 0);

        // Single press of KEY_UP at cycle 10, consumer ready
        for (int i = 0; i < 10; i++) tick();
        drive(4'b0100, 1'b1);
        tick();
        chk("single E0 valid", int'(bus.ev_valid), 0);
        drive(4'b0000, 1'b1);
        tick();
        chk("single E1 valid", int'(bus.ev_valid), 1);
        chk("single E1 code", int'(bus.ev_code), int'(KEY_UP));
        chk("single E1 count", int'(bus.ev_count), 1);
        tick();
        chk("single E2 valid", int'(bus.ev_valid), 0);
        chk("single E2 count", int'(bus.ev_count), 0);

        for (int i = 0; i <= 6; i++) apply(i);
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 7; i <= 18; i++) apply(i);
        end
        for (int i = 19; i < tbl.size(); i++) apply(i);

`ifdef KEY_EVENT_QUEUE_OVF_CLR_EN
        drive(4'b0000, 1'b0);
        bus.overflow_clr = 1'b1;
        tick();
        chk("clr overflow", int'(bus.overflow), 0);
        bus.overflow_clr = 1'b0;
        drive(4'b0011, 1'b0);
        tick();
        // key 0 is pushed, key 1 stays pending and its second press drops
        bus.overflow_clr = 1'b1;
        drive(4'b0010, 1'b0);
        tick();
        chk("clr vs drop overflow", int'(bus.overflow), 1);
        chk("clr vs drop count", int'(bus.ev_count), 1);
        drive(4'b0000, 1'b0);
        tick();
        chk("clr again overflow", int'(bus.overflow), 0);
        chk("clr again count", int'(bus.ev_count), 2);
        bus.overflow_clr = 1'b0;
        drive(4'b0000, 1'b1);
        tick();
        tick();
        chk("clr drain count", int'(bus.ev_count), 0);
`endif

        // Asynchronous reset with three queued and two pending
        drive(4'b0111, 1'b0);
        tick();
        drive(4'b0000, 1'b0);
        tick();
        drive(4'b1001, 1'b0);
        tick();
        drive(4'b0000, 1'b0);
        tick();
        chk("pre-reset count", int'(bus.ev_count), 3);
        #2 reset = 1'b1;
        #1;
        chk("async reset valid", int'(bus.ev_valid), 0);
        chk("async reset count", int'(bus.ev_count), 0);
        chk("async reset overflow", int'(bus.overflow), 0);
        chk("async reset code", int'(bus.ev_code), 0);
        #3 reset = 1'b0;
        drive(4'b0010, 1'b0);
        tick();
        chk("post-reset E0 valid", int'(bus.ev_valid), 0);
        drive(4'b0000, 1'b0);
        tick();
        chk("post-reset E1 valid", int'(bus.ev_valid), 1);
        chk("post-reset E1 code", int'(bus.ev_code), int'(KEY_BACK));
        chk("post-reset E1 count", int'(bus.ev_count), 1);
        drive(4'b0000, 1'b1);
        tick();
        tick();
        chk("post-reset drained valid", int'(bus.ev_valid), 0);
        chk("post-reset drained count", int'(bus.ev_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
# key_event_queue

Collects single-cycle press pulses from up to NUM_KEYS debouncers and turns them into an ordered stream of key codes for the control FSM. Each key has a one-deep pending latch, so simultaneous presses are never lost. A lowest-index-first arbiter moves pending keys into a small FIFO. The consumer drains the FIFO through a valid/ready handshake. The block sits directly between the per-key debouncer outputs and the menu/command control logic.

## Interface
- NUM_KEYS, 4: number of key pulse inputs; legal range 2–8.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  reset, asynchronous, active-high.
- key_pulse  in  NUM_KEYS  one-cycle press pulses; bit i comes from the debouncer of key i.
- ev_valid  out  1  FIFO non-empty; ev_code is meaningful.
- ev_ready  in  1  consumer accepts the head entry this cycle.
- ev_code  out  $clog2(NUM_KEYS)  key index at the FIFO head.
- ev_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: at least one press was dropped.
- overflow_clr  in  1  synchronous clear of overflow. Present only with KEY_EVENT_QUEUE_OVF_CLR_EN.

## Operation
- Reset values: pending = 0, FIFO empty, ev_valid = 0, ev_code = 0, ev_count = 0, overflow = 0.
- Capture: on each edge, pending[i] is set if key_pulse[i] = 1.
- Drop rule: if key_pulse[i] = 1 while pending[i] is already 1 and is not being pushed this cycle, the press is dropped and overflow is set.
- Arbitration: each cycle, pick the lowest index i with pending[i] = 1.
- Push: the chosen index is pushed and pending[i] is cleared when ev_count < DEPTH, or when a pop happens in the same cycle.
- Push arbitration uses registered pending only. A pulse arriving this cycle is not pushable until the next cycle.
- Pop: occurs when ev_valid && ev_ready. ev_ready is ignored while ev_valid = 0.
- Simultaneous push and pop: ev_count is unchanged, pointers both advance, and ordering is preserved.
- FIFO full with keys pending: pending bits hold. No drop happens until the same key pulses again.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full and empty are derived from ev_count, never from pointer equality.
- ev_code is driven from the registered head entry. It holds a stable value while ev_valid = 1 and ev_ready = 0.
- Reset asserted mid-operation: all pending presses and queued entries are discarded. Outputs take their reset values asynchronously.

## Timing
- Latency from a pulse on edge E0 into an empty, idle queue: pending is set at E0, the entry is pushed at E1, and ev_valid = 1 after E1. Two cycles from pulse to visible event.
- Throughput: one push and one pop per cycle.
- N simultaneous pulses appear as N consecutive entries in ascending index order, one per cycle.
- overflow is set on the edge following the dropped pulse.
- overflow_clr and a new drop in the same cycle: overflow = 1 (set wins).
- ev_count updates on the same edge as the push or pop.

## Configuration
- KEY_EVENT_QUEUE_OVF_CLR_EN defined: the overflow_clr port exists. overflow is cleared on the next edge when overflow_clr = 1, unless a drop happens in the same cycle.
- Macro undefined: no overflow_clr port. overflow clears only on reset.

## Structure
- Package key_event_pkg contains:
  - localparam KEY_IDX_W;
  - the key index constants: KEY_CONFIRM = 0, KEY_BACK = 1, KEY_UP = 2, KEY_DOWN = 3;
  - function lowest_set, a priority encoder returning the index and a found flag.
- Sub-module key_event_fifo: synchronous FIFO with push/pop, head data, and count, parameterised by DEPTH and width. The pending latches and the arbiter stay in the top module.

## Test plan
- Single press: after reset, pulse key 2 at cycle 10, ev_ready = 1 → ev_valid = 1 during cycle 12 with ev_code = 2, then ev_valid = 0 and ev_count = 0.
- Simultaneous press: key_pulse = 4'b1011 in one cycle, ev_ready = 0 → ev_count climbs to 3 over 3 cycles; draining yields codes 0, 1, 3 in that order.
- Backpressure and wrap: with ev_ready = 0, push 4 events (codes 3, 2, 1, 0) → ev_count = 4 and ev_code holds 3. Pulse key 1 → it stays pending with no overflow. Then set ev_ready = 1 → output order is 3, 2, 1, 0, 1. Repeat 3 times to exercise pointer wrap.
- Drop: FIFO full and key 0 pending, pulse key 0 again → overflow = 1 on the next edge and queued contents unchanged. With the macro defined, overflow_clr = 1 → overflow = 0.
- Simultaneous push and pop at full: ev_count = 4, ev_ready = 1, key 3 pending → ev_count stays 4 and the entry 3 appears last in the drained order.
- Asynchronous reset mid-stream: assert reset between edges while ev_count = 3 with 2 keys pending → ev_valid, ev_count, and overflow go to 0 immediately. The first press after reset is delivered normally.
